// File: rtl/mips_pkg.sv
// Shared pipeline types for the memory/writeback end of the datapath:
// word and register-address types, stage control bundles and the memory FSM state.
package mips_pkg;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  regaddr_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } exmem_ctrl_t;

  typedef struct packed {
    regaddr_t write_addr;
    logic     reg_write;
  } memwb_ctrl_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  function automatic logic is_mem_op(input exmem_ctrl_t c);
    return c.mem_read | c.mem_write;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: asynchronous read, synchronous write with enable.
// Contents are deliberately not reset.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers around a wait-stated data memory.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  word_t      alu_res,
  input  word_t      RS2_sw,
  input  regaddr_t   write_addr_IDEX,
  input  logic       reg_write_IDEX,
  input  logic       mem_read_IDEX,
  input  logic       mem_write_IDEX,
  input  logic       mem_to_reg_IDEX,
  input  logic       flush_in,
  output word_t      alu_res_EXMEM,
  output regaddr_t   write_addr_EXMEM,
  output logic       reg_write_EXMEM,
  output logic       mem_read_EXMEM,
  output word_t      write_data,
  output regaddr_t   write_addr_MEMWB,
  output logic       reg_write_MEMWB,
  output logic       stall_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic       misalign_trap,
`endif
  output mem_state_t dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY);

  word_t       ex_alu;
  word_t       ex_store;
  regaddr_t    ex_waddr;
  exmem_ctrl_t ex_ctrl;
  word_t       wb_data;
  memwb_ctrl_t wb_ctrl;
  mem_state_t  state;
  logic [CW-1:0] cnt;

  logic    mem_op;
  logic    stall;
  logic    misalign;
  logic    mem_we;
  word_t   load_data;
  logic [AW-1:0] mem_idx;

  assign mem_op  = is_mem_op(ex_ctrl);
  assign mem_idx = ex_alu[AW+1:2];

  // stall acts as the stage's not-ready: while high, EX/MEM holds its
  // instruction and upstream must hold its inputs; the access completes on
  // the first edge where stall is low.
  always_comb begin
    stall = 1'b0;
    if (MEM_LATENCY > 0)
      stall = mem_op & ~((state == WAIT) && (cnt == CNT_LAST));
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op & (ex_alu[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_we = ~stall & ex_ctrl.mem_write & ~misalign;

  data_mem #(.DEPTH(DEPTH), .AW(AW)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (ex_store),
    .rdata (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((MEM_LATENCY > 0) && mem_op) begin
            state <= WAIT;
            cnt   <= CW'(1);
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // $zero is never a write target, so its reg_write is dropped on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_alu   <= '0;
      ex_store <= '0;
      ex_waddr <= '0;
      ex_ctrl  <= '0;
    end else if (!stall) begin
      ex_alu             <= alu_res;
      ex_store           <= RS2_sw;
      ex_waddr           <= write_addr_IDEX;
      ex_ctrl.reg_write  <= reg_write_IDEX & (write_addr_IDEX != '0) & ~flush_in;
      ex_ctrl.mem_read   <= mem_read_IDEX & ~flush_in;
      ex_ctrl.mem_write  <= mem_write_IDEX & ~flush_in;
      ex_ctrl.mem_to_reg <= mem_to_reg_IDEX;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data <= '0;
      wb_ctrl <= '0;
    end else if (!stall) begin
      wb_data            <= ex_ctrl.mem_to_reg ? load_data : ex_alu;
      wb_ctrl.write_addr <= ex_waddr;
      wb_ctrl.reg_write  <= ex_ctrl.reg_write & ~misalign;
    end else begin
      wb_ctrl.reg_write  <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic wb_trap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       wb_trap <= 1'b0;
    else if (!stall) wb_trap <= misalign;
  end

  assign misalign_trap = wb_trap;
`endif

  assign alu_res_EXMEM    = ex_alu;
  assign write_addr_EXMEM = ex_waddr;
  assign reg_write_EXMEM  = ex_ctrl.reg_write;
  assign mem_read_EXMEM   = ex_ctrl.mem_read;
  assign write_data       = wb_data;
  assign write_addr_MEMWB = wb_ctrl.write_addr;
  assign reg_write_MEMWB  = wb_ctrl.reg_write;
  assign stall_out        = stall;
  assign dbg_state        = state;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes expected EX/MEM and MEM/WB
// results from a reference memory model; a monitor pops and compares them.
module tb_mem_wb_stage;
  import mips_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int AW    = 8;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic        trap;
    logic [3:0]  stall;
    logic [31:0] data;
    logic [7:0]  addr;
    logic        rw;
  } wb_exp_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [7:0]  addr;
    logic        rw;
    logic        mr;
  } exm_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  word_t      alu_res, RS2_sw;
  regaddr_t   write_addr_IDEX;
  logic       reg_write_IDEX, mem_read_IDEX, mem_write_IDEX, mem_to_reg_IDEX, flush_in;
  word_t      alu_res_EXMEM, write_data;
  regaddr_t   write_addr_EXMEM, write_addr_MEMWB;
  logic       reg_write_EXMEM, mem_read_EXMEM, reg_write_MEMWB, stall_out;
  mem_state_t dbg_state;
`ifdef MEM_MISALIGN_TRAP_EN
  logic       misalign_trap;
`endif

  mem_wb_stage #(.DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_res          (alu_res),
    .RS2_sw           (RS2_sw),
    .write_addr_IDEX  (write_addr_IDEX),
    .reg_write_IDEX   (reg_write_IDEX),
    .mem_read_IDEX    (mem_read_IDEX),
    .mem_write_IDEX   (mem_write_IDEX),
    .mem_to_reg_IDEX  (mem_to_reg_IDEX),
    .flush_in         (flush_in),
    .alu_res_EXMEM    (alu_res_EXMEM),
    .write_addr_EXMEM (write_addr_EXMEM),
    .reg_write_EXMEM  (reg_write_EXMEM),
    .mem_read_EXMEM   (mem_read_EXMEM),
    .write_data       (write_data),
    .write_addr_MEMWB (write_addr_MEMWB),
    .reg_write_MEMWB  (reg_write_MEMWB),
    .stall_out        (stall_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_trap    (misalign_trap),
`endif
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [$bits(wb_exp_t)-1:0]  exp_q[$];
  logic [$bits(exm_exp_t)-1:0] exm_q[$];
  logic [31:0] model_mem [DEPTH];
  bit presenting = 1'b0;
  bit exmem_has  = 1'b0;
  int stall_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"},   stall_out, 0);
    check({tag, "_alu_exm"}, alu_res_EXMEM, 0);
    check({tag, "_wa_exm"},  write_addr_EXMEM, 0);
    check({tag, "_rw_exm"},  reg_write_EXMEM, 0);
    check({tag, "_mr_exm"},  mem_read_EXMEM, 0);
    check({tag, "_wdata"},   write_data, 0);
    check({tag, "_wa_mwb"},  write_addr_MEMWB, 0);
    check({tag, "_rw_mwb"},  reg_write_MEMWB, 0);
    check({tag, "_state"},   dbg_state, IDLE);
  endtask

  task automatic idle_inputs();
    alu_res = '0; RS2_sw = '0; write_addr_IDEX = '0;
    reg_write_IDEX = 0; mem_read_IDEX = 0; mem_write_IDEX = 0;
    mem_to_reg_IDEX = 0; flush_in = 0;
  endtask

  // Called at a negedge; returns at the negedge after the instruction entered EX/MEM.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [7:0] wa,
                       input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic fl);
    logic mop, mis, rw_e;
    logic [AW-1:0] idx;
    wb_exp_t  e;
    exm_exp_t x;
    bit done;
    mop  = (mr | mw) & ~fl;
    idx  = alu[AW+1:2];
    mis  = TRAP_EN & mop & (alu[1:0] != 2'b00);
    rw_e = rw & (wa != 8'd0) & ~fl;
    x.alu = alu; x.addr = wa; x.rw = rw_e; x.mr = mr & ~fl;
    exm_q.push_back(x);
    e.trap  = mis;
    e.stall = mop ? 4'(LAT) : 4'd0;
    e.data  = m2r ? model_mem[idx] : alu;
    e.addr  = wa;
    e.rw    = rw_e & ~mis;
    exp_q.push_back(e);
    if (mw && !fl && !mis) model_mem[idx] = sd;
    alu_res = alu; RS2_sw = sd; write_addr_IDEX = wa;
    reg_write_IDEX = rw; mem_read_IDEX = mr; mem_write_IDEX = mw;
    mem_to_reg_IDEX = m2r; flush_in = fl;
    presenting = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (!stall_out) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("issue_timeout", 0, 1);
    @(negedge clk);
    idle_inputs();
    presenting = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    wb_exp_t  e;
    exm_exp_t x;
    logic rst_s, stall_s, pres_s;
    forever begin
      @(posedge clk);
      rst_s = reset; stall_s = stall_out; pres_s = presenting;
      #1;
      if (!rst_s) begin
        if (stall_s) begin
          check("mwb_bubble", reg_write_MEMWB, 0);
          stall_cnt++;
        end else begin
          if (exmem_has) begin
            if (exp_q.size() == 0) check("wb_underflow", 1, 0);
            else begin
              e = exp_q.pop_front();
              check("wb_data", write_data, e.data);
              check("wb_addr", write_addr_MEMWB, e.addr);
              check("wb_rw", reg_write_MEMWB, e.rw);
              check("stall_cycles", stall_cnt, e.stall);
`ifdef MEM_MISALIGN_TRAP_EN
              check("wb_trap", misalign_trap, e.trap);
`endif
            end
          end
          stall_cnt = 0;
          exmem_has = pres_s;
          if (pres_s) begin
            if (exm_q.size() == 0) check("exm_underflow", 1, 0);
            else begin
              x = exm_q.pop_front();
              check("exm_alu", alu_res_EXMEM, x.alu);
              check("exm_addr", write_addr_EXMEM, x.addr);
              check("exm_rw", reg_write_EXMEM, x.rw);
              check("exm_mr", mem_read_EXMEM, x.mr);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // driver
  initial begin
    exm_exp_t x;
    logic [31:0] a;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    issue(32'h10, 0, 8'd5, 1, 0, 0, 0, 0);
    issue(32'h40, 32'hDEADBEEF, 8'd0, 0, 0, 1, 0, 0);
    issue(32'h40, 0, 8'd7, 1, 1, 0, 1, 0);
    issue(4 * DEPTH + 8, 32'h1234, 8'd0, 0, 0, 1, 0, 0);
    issue(32'h8, 0, 8'd9, 1, 1, 0, 1, 0);
    issue(32'h77, 0, 8'd0, 1, 0, 0, 0, 0);
    issue(32'h40, 32'h1111, 8'd3, 1, 0, 1, 0, 1);
    issue(32'h40, 0, 8'd4, 1, 1, 0, 1, 0);

    for (int i = 0; i < 4; i++) issue(32'h100 + 4 * i, $urandom, 8'd0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 24; i++) begin
      int r;
      logic [7:0] wa;
      logic fl;
      r  = $urandom_range(0, 2);
      a  = 32'h100 + 4 * $urandom_range(0, 3);
      wa = 8'($urandom_range(0, 31));
      fl = ($urandom_range(0, 7) == 0);
      case (r)
        0:       issue($urandom, 0, wa, 1, 0, 0, 0, fl);
        1:       issue(a, $urandom, 8'd0, 0, 0, 1, 0, fl);
        default: issue(a, 0, wa, 1, 1, 0, 1, fl);
      endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    issue(32'h42, 0, 8'd6, 1, 1, 0, 1, 0);
    issue(32'h42, 32'hCAFE, 8'd0, 0, 0, 1, 0, 0);
    issue(32'h40, 0, 8'd6, 1, 1, 0, 1, 0);
`endif

    // reset in the middle of a store: the store must be abandoned
    issue(32'h80, 32'h55, 8'd0, 0, 0, 1, 0, 0);
    repeat (4) @(negedge clk);
    x.alu = 32'h80; x.addr = 8'd0; x.rw = 1'b0; x.mr = 1'b0;
    exm_q.push_back(x);
    alu_res = 32'h80; RS2_sw = 32'hBAD; mem_write_IDEX = 1'b1;
    presenting = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_stall_pre", stall_out, 1);
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    idle_inputs();
    presenting = 1'b0;
    exp_q.delete();
    exm_q.delete();
    exmem_has = 1'b0;
    stall_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    issue(32'h80, 0, 8'd10, 1, 1, 0, 1, 0);

    repeat (6) @(negedge clk);
    check("drain_wb", exp_q.size(), 0);
    check("drain_exm", exm_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
